// File: rtl/led_fader_pkg.sv
// Shared definitions for the LED fader: channel count, PWM resolution and
// the saturating brightness arithmetic used by every channel.
// No ports (package).
package led_fader_pkg;

  localparam int LED_COUNT = 8;
  localparam int PWM_BITS  = 8;
  localparam int PWM_MAX   = (1 << PWM_BITS) - 1;

  typedef logic [PWM_BITS-1:0] bright_t;
  typedef logic [PWM_BITS:0]   wide_t;

  // One extra bit holds the carry so the clamp can see an overflow.
  function automatic bright_t sat_add(input bright_t a, input bright_t step);
    wide_t sum;
    sum = {1'b0, a} + {1'b0, step};
    if (sum > wide_t'(PWM_MAX)) begin
      return bright_t'(PWM_MAX);
    end
    return sum[PWM_BITS-1:0];
  endfunction

  // The extra bit becomes a borrow flag; a borrow means the result went below 0.
  function automatic bright_t sat_sub(input bright_t a, input bright_t step);
    wide_t diff;
    diff = {1'b0, a} - {1'b0, step};
    if (diff[PWM_BITS]) begin
      return '0;
    end
    return diff[PWM_BITS-1:0];
  endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One fading LED channel: holds the channel brightness, ramps it toward the
// requested level on each enabled tick, and compares it against the shared
// PWM counter to produce the registered active-low LED drive.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   tick_i        ramp tick from the shared prescaler
//   en_i          enable; low freezes the ramp and forces the LED off
//   req_n_i       registered request bit, active-low (0 = LED wanted on)
//   pwm_cnt_i     shared free-running PWM counter
//   led_n_o       registered PWM drive, active-low
//   busy_o        brightness has not yet reached its target
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic                en_i,
  input  logic                req_n_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_n_o,
  output logic                busy_o
);

  localparam bright_t STEP_V = bright_t'(STEP);

  bright_t bright_q, bright_d;
  bright_t target;
  logic    led_n_q, led_n_d;

  always_comb begin
    target   = req_n_i ? '0 : bright_t'(PWM_MAX);
    bright_d = bright_q;
    if (tick_i && en_i) begin
      if (bright_q < target) begin
        bright_d = sat_add(bright_q, STEP_V);
      end else if (bright_q > target) begin
        bright_d = sat_sub(bright_q, STEP_V);
      end
    end
    // pwm_cnt never reaches PWM_MAX, so full brightness is a solid on.
    led_n_d = ~(en_i & (pwm_cnt_i < bright_q));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bright_q <= '0;
      led_n_q  <= 1'b1;
    end else begin
      bright_q <= bright_d;
      led_n_q  <= led_n_d;
    end
  end

  assign led_n_o = led_n_q;
  assign busy_o  = (bright_q != target);

endmodule

// File: rtl/led_fader.sv
// LED fader output stage: takes the active-low LED pattern from the blink
// core and drives the board LEDs with a linear PWM brightness ramp per LED.
// Owns the input register, ramp prescaler, shared PWM counter and the busy
// reduction; each LED is a led_fader_channel instance.
// PWM resolution comes from led_fader_pkg.
// Ports:
//   clk_i     fader clock (PLL CLK0)
//   rst_i     asynchronous active-high reset
//   en_i      enable; low freezes ramps and forces all LEDs off
//   led_n_i   requested pattern, active-low, synchronous to clk_i
//   led_n_o   registered PWM LED drive, active-low
//   busy_o    any channel still ramping toward its target
module led_fader
  import led_fader_pkg::*;
#(
  parameter int STEP     = 8,
  parameter int STEP_DIV = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [LED_COUNT-1:0] led_n_i,
  output logic [LED_COUNT-1:0] led_n_o,
  output logic                 busy_o
);

  localparam int                PS_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(STEP_DIV - 1);
  localparam bright_t           PWM_LAST = bright_t'(PWM_MAX - 1);

  logic [LED_COUNT-1:0] req_n_q, req_n_d;
  logic [PS_W-1:0]      ps_q, ps_d;
  bright_t              pwm_cnt_q, pwm_cnt_d;
  logic                 tick;
  logic [LED_COUNT-1:0] busy_vec;

  always_comb begin
    req_n_d   = led_n_i;
    tick      = (ps_q == PS_LAST);
    ps_d      = tick ? '0 : ps_q + PS_W'(1);
    // Period is PWM_MAX cycles so that brightness PWM_MAX stays on throughout.
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + bright_t'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_n_q   <= '1;
      ps_q      <= '0;
      pwm_cnt_q <= '0;
    end else begin
      req_n_q   <= req_n_d;
      ps_q      <= ps_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar k = 0; k < LED_COUNT; k++) begin : g_ch
    led_fader_channel #(
      .STEP(STEP)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tick_i    (tick),
      .en_i      (en_i),
      .req_n_i   (req_n_q[k]),
      .pwm_cnt_i (pwm_cnt_q),
      .led_n_o   (led_n_o[k]),
      .busy_o    (busy_vec[k])
    );
  end

  assign busy_o = |busy_vec;

endmodule
